// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmit framing stage. On an accepted send request it
//               captures the data word, the precomputed parity bit and the
//               frame shape. It then emits start, data (LSB first), optional
//               parity and one or two stop bits, one bit per baud_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_bit,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  // Bit counter wide enough to index every data bit (at least one bit wide).
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_bit;
  logic                  r_par_en;
  logic [1:0]            r_stop_n;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [1:0]            r_stop_cnt;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  // Frame sequencer: the state, shadow registers, counters and all outputs
  // are registered here. Outside IDLE, nothing moves except on a baud_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop_n   <= 2'd0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 2'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the completion tick raises it.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          // Acceptance ignores any coincident baud_tick; the start bit waits
          // for the first tick strictly after this cycle.
          if (send) begin
            r_data    <= data_in;
            r_par_bit <= parity_bit;
            r_par_en  <= (parity_type == 2'b01) || (parity_type == 2'b10);
            r_stop_n  <= stop_bits ? 2'd2 : 2'd1;
            r_busy    <= 1'b1;
            r_state   <= ST_START;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            r_tx      <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            r_tx <= r_data[r_bit_cnt];
            if (r_bit_cnt == c_BIT_LAST) begin
              r_stop_cnt <= 2'd0;
              r_state    <= r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (baud_tick) begin
            r_tx    <= r_par_bit;
            r_state <= ST_STOP;
          end
        end

        ST_STOP: begin
          // Each tick either starts another stop period or, once all stop
          // periods have run, closes the frame.
          if (baud_tick) begin
            r_tx <= 1'b1;
            if (r_stop_cnt == r_stop_n) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Self-checking bench for uart_tx_frame. Expected line levels
//               come from a slot list built from the framing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       send;
  logic [7:0] data_in;
  logic       parity_bit;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .send       (send),
    .data_in    (data_in),
    .parity_bit (parity_bit),
    .parity_type(parity_type),
    .stop_bits  (stop_bits),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Line levels of one frame, in the order they appear on tx.
  task automatic build_slots(input logic [7:0] d, input logic pb,
                             input logic [1:0] pt, input logic sb);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pt == 2'b01 || pt == 2'b10) exp_q.push_back(pb);
    repeat (sb ? 2 : 1) exp_q.push_back(1'b1);
  endtask

  // What a correct parity generator would supply for this data word.
  function automatic logic par_for(input logic [7:0] d, input logic [1:0] pt);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (pt == 2'b01) return (ones % 2 == 0);
    if (pt == 2'b10) return (ones % 2 == 1);
    return 1'b1;
  endfunction

  // Sends one frame with ticks spaced glo..ghi clocks apart and checks every
  // cycle. inject_at pulses send before that tick; abort_at applies reset
  // in place of that tick.
  task automatic run_frame(input logic [7:0] d, input logic pb,
                           input logic [1:0] pt, input logic sb,
                           input int glo, input int ghi, input bit coinc,
                           input int inject_at, input int abort_at);
    int   gap;
    logic prev;
    build_slots(d, pb, pt, sb);
    data_in = d; parity_bit = pb; parity_type = pt; stop_bits = sb;
    send = 1'b1; baud_tick = coinc;
    @(posedge clk); @(negedge clk);
    send = 1'b0; baud_tick = 1'b0;
    // Scramble the inputs to confirm the frame uses the captured copy.
    data_in = ~d; parity_bit = ~pb; parity_type = 2'($urandom); stop_bits = ~sb;
    check(busy, 1'b1, "accept_busy");
    check(tx, 1'b1, "accept_tx");
    check(done, 1'b0, "accept_done");
    prev = 1'b1;
    for (int k = 0; k <= exp_q.size(); k++) begin
      gap = int'($urandom_range(ghi, glo));
      if (k == abort_at) begin
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check(tx, 1'b1, "abort_tx");
        check(busy, 1'b0, "abort_busy");
        check(done, 1'b0, "abort_done");
        return;
      end
      if (k == inject_at) begin
        send = 1'b1;
        @(posedge clk); @(negedge clk);
        send = 1'b0;
        check(tx, prev, "inject_tx");
        check(busy, 1'b1, "inject_busy");
      end
      repeat (gap - 1) begin
        @(posedge clk); @(negedge clk);
        check(tx, prev, "hold_tx");
        check(done, 1'b0, "hold_done");
      end
      baud_tick = 1'b1;
      @(posedge clk); @(negedge clk);
      baud_tick = 1'b0;
      if (k < exp_q.size()) begin
        check(tx, exp_q[k], "slot_tx");
        check(busy, 1'b1, "slot_busy");
        check(done, 1'b0, "slot_done");
        prev = exp_q[k];
      end else begin
        check(done, 1'b1, "done_pulse");
        check(busy, 1'b0, "done_busy");
        check(tx, 1'b1, "done_tx");
      end
    end
    @(posedge clk); @(negedge clk);
    check(done, 1'b0, "done_width");
    check(busy, 1'b0, "idle_busy");
    // A further tick with no request must not start anything.
    baud_tick = 1'b1;
    @(posedge clk); @(negedge clk);
    baud_tick = 1'b0;
    check(tx, 1'b1, "idle_tx");
    check(busy, 1'b0, "no_second_frame");
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] pt;
    logic       sb;
    reset = 1'b1; baud_tick = 1'b0; send = 1'b0;
    data_in = 8'h00; parity_bit = 1'b0; parity_type = 2'b00; stop_bits = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(tx, 1'b1, "reset_tx");
    check(busy, 1'b0, "reset_busy");
    check(done, 1'b0, "reset_done");
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check(tx, 1'b1, "post_reset_tx");

    // Directed frames with a tick every 16 clocks.
    run_frame(8'hAF, 1'b1, 2'b01, 1'b0, 16, 16, 1'b0, -1, -1);
    run_frame(8'hA3, 1'b0, 2'b10, 1'b1, 16, 16, 1'b0, -1, -1);
    run_frame(8'h55, 1'b1, 2'b00, 1'b0, 16, 16, 1'b0, -1, -1);
    run_frame(8'h55, 1'b0, 2'b11, 1'b0, 16, 16, 1'b0, -1, -1);

    // send during data bit 4 (slot 5) is ignored; send with a tick in IDLE.
    run_frame(8'h3C, par_for(8'h3C, 2'b01), 2'b01, 1'b1, 3, 6, 1'b0, 5, -1);
    run_frame(8'hC5, par_for(8'hC5, 2'b10), 2'b10, 1'b0, 2, 5, 1'b1, -1, -1);

    // Reset during data bit 3 (slot 4), then a fresh complete frame.
    run_frame(8'h96, 1'b0, 2'b10, 1'b1, 4, 4, 1'b0, -1, 4);
    run_frame(8'h96, par_for(8'h96, 2'b10), 2'b10, 1'b1, 4, 4, 1'b0, -1, -1);

    // Randomised frames, including tick every clock.
    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      pt = 2'($urandom);
      sb = 1'($urandom);
      run_frame(d, par_for(d, pt), pt, sb, 1, (n % 2 == 0) ? 1 : 8,
                1'($urandom), -1, -1);
    end

    // baud_tick tied high and send held: back-to-back frames.
    d = 8'($urandom); pt = 2'($urandom); sb = 1'($urandom);
    data_in = d; parity_bit = par_for(d, pt); parity_type = pt; stop_bits = sb;
    build_slots(d, par_for(d, pt), pt, sb);
    baud_tick = 1'b1; send = 1'b1;
    @(posedge clk); @(negedge clk);
    check(busy, 1'b1, "b2b_accept_busy");
    check(tx, 1'b1, "b2b_accept_tx");
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        @(posedge clk); @(negedge clk);
        check(tx, exp_q[k], "b2b_slot_tx");
        check(busy, 1'b1, "b2b_slot_busy");
        check(done, 1'b0, "b2b_slot_done");
      end
      @(posedge clk); @(negedge clk);
      check(done, 1'b1, "b2b_done");
      check(busy, 1'b0, "b2b_done_busy");
      check(tx, 1'b1, "b2b_done_tx");
      // New fields are captured at the end of this done cycle.
      d = 8'($urandom); pt = 2'($urandom); sb = 1'($urandom);
      data_in = d; parity_bit = par_for(d, pt); parity_type = pt; stop_bits = sb;
      build_slots(d, par_for(d, pt), pt, sb);
      if (f == 2) send = 1'b0;
      @(posedge clk); @(negedge clk);
      check(done, 1'b0, "b2b_done_width");
      check(busy, (f != 2), "b2b_reaccept_busy");
      check(tx, 1'b1, "b2b_reaccept_tx");
    end
    baud_tick = 1'b0;
    @(posedge clk); @(negedge clk);
    check(busy, 1'b0, "final_idle_busy");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
